// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encodings, parity codes and defaults for the UART
package uart_tx_pkg;

  // Frame states of the transmitter FSM
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // Parity mode codes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 50 MHz system clock, 115200 baud
  localparam int CLKDIV_DEFAULT = 434;

  // Parity bit for a captured byte; odd mode inverts the even result
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// rtl/uart_baudgen.sv - loadable bit-period down-counter with a boundary tick
module uart_baudgen #(
  parameter int CLKDIV = 434
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load_i,
  output logic tick_o
);

  localparam int W = $clog2(CLKDIV);
  localparam logic [W-1:0] RELOAD = W'(CLKDIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // tick marks the last clock of the current bit period
  assign tick_o = (cnt_q == '0);

  // Restart on load, reload at every boundary, otherwise count down
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (load_i || tick_o) begin
      cnt_d = RELOAD;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-serial UART transmitter, 8 data bits LSB first
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKDIV   = CLKDIV_DEFAULT,
  parameter int PARITY   = PAR_NONE,
  parameter int STOPBITS = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       txen,
  input  logic [7:0] datain,
  output logic       busy,
  output logic       tx
);

  if (CLKDIV < 2) begin : g_bad_clkdiv
    $error("uart_tx: CLKDIV must be >= 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_tx: STOPBITS must be 1 or 2");
  end

  localparam logic LAST_STOP = (STOPBITS == 2);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       load;
  logic       tick;

  uart_baudgen #(.CLKDIV(CLKDIV)) u_baudgen (
    .clk    (clk),
    .n_rst  (n_rst),
    .load_i (load),
    .tick_o (tick)
  );

  assign busy = busy_q;
  assign tx   = tx_q;

  // Next-state and output logic; every bit change happens on a timer boundary
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (txen) begin
          // Parity is taken from the captured byte so later datain changes cannot leak in
          shift_d = datain;
          par_d   = parity_bit(datain, PARITY);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            stop_d = 1'b0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  localparam int CD = 4;
  localparam int PAR_CFG[4]  = '{0, 1, 2, 1};
  localparam int STOP_CFG[4] = '{1, 1, 1, 2};

  logic       clk;
  logic       n_rst;
  logic       txen[4];
  logic [7:0] datain[4];
  logic       busy_w[4];
  logic       tx_w[4];
  logic       cap[64];

  int checks;
  int failures;

  uart_tx #(.CLKDIV(CD), .PARITY(0), .STOPBITS(1)) dut0 (
    .clk(clk), .n_rst(n_rst), .txen(txen[0]), .datain(datain[0]), .busy(busy_w[0]), .tx(tx_w[0]));
  uart_tx #(.CLKDIV(CD), .PARITY(1), .STOPBITS(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .txen(txen[1]), .datain(datain[1]), .busy(busy_w[1]), .tx(tx_w[1]));
  uart_tx #(.CLKDIV(CD), .PARITY(2), .STOPBITS(1)) dut2 (
    .clk(clk), .n_rst(n_rst), .txen(txen[2]), .datain(datain[2]), .busy(busy_w[2]), .tx(tx_w[2]));
  uart_tx #(.CLKDIV(CD), .PARITY(1), .STOPBITS(2)) dut3 (
    .clk(clk), .n_rst(n_rst), .txen(txen[3]), .datain(datain[3]), .busy(busy_w[3]), .tx(tx_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frame_len(input int idx);
    return 10 + ((PAR_CFG[idx] != 0) ? 1 : 0) + (STOP_CFG[idx] - 1);
  endfunction

  function automatic logic exp_bit(input int idx, input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && PAR_CFG[idx] == 1) return ^b;
    if (pos == 9 && PAR_CFG[idx] == 2) return ~(^b);
    return 1'b1;
  endfunction

  // Pulse txen for one cycle; caller is positioned at a negedge
  task automatic send(input int idx, input logic [7:0] b);
    txen[idx]   = 1'b1;
    datain[idx] = b;
    @(negedge clk);
    txen[idx]   = 1'b0;
  endtask

  // Called one negedge after the accepting edge; walks the whole frame and ends
  // on the first negedge where busy must read 0
  task automatic check_frame(input int idx, input logic [7:0] b, input string name,
                             input int dist_at, input logic [7:0] dist_b);
    int len;
    logic [7:0] rx;
    len = frame_len(idx) * CD;
    for (int k = 0; k < len; k++) begin
      cap[k] = tx_w[idx];
      checks++;
      if (tx_w[idx] !== exp_bit(idx, b, k / CD)) begin
        failures++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, k, tx_w[idx], exp_bit(idx, b, k / CD));
      end
      checks++;
      if (busy_w[idx] !== 1'b1) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy_w[idx]);
      end
      if (dist_at >= 0) begin
        if (k == dist_at) begin
          txen[idx]   = 1'b1;
          datain[idx] = dist_b;
        end else begin
          txen[idx]   = 1'b0;
          datain[idx] = ~datain[idx];
        end
      end
      @(negedge clk);
    end
    txen[idx] = 1'b0;
    checks++;
    if (busy_w[idx] !== 1'b0 || tx_w[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s end: busy=%b tx=%b want busy=0 tx=1", name, busy_w[idx], tx_w[idx]);
    end
    for (int j = 0; j < 8; j++) rx[j] = cap[(j + 1) * CD + 2];
    checks++;
    if (rx !== b) begin
      failures++;
      $display("FAIL %s decode: got %h want %h", name, rx, b);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      txen[i]   = 1'b0;
      datain[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d: tx=%b busy=%b want tx=1 busy=0", i, tx_w[i], busy_w[i]);
      end
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL idle inst%0d: tx=%b busy=%b want tx=1 busy=0", i, tx_w[i], busy_w[i]);
      end
    end
  endtask

  task automatic test_frame_shape();
    checks++;
    if (busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL shape pre-busy: got %b want 0", busy_w[0]);
    end
    send(0, 8'h50);
    check_frame(0, 8'h50, "shape_50", -1, 8'h00);
  endtask

  task automatic test_busy_ignore();
    send(0, 8'h2C);
    check_frame(0, 8'h2C, "ignore_2C", 9, 8'h41);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
        failures++;
        $display("FAIL ignore idle %0d: busy=%b tx=%b want busy=0 tx=1", k, busy_w[0], tx_w[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    send(0, 8'h0A);
    check_frame(0, 8'h0A, "b2b_first", -1, 8'h00);
    send(0, 8'h0A);
    check_frame(0, 8'h0A, "b2b_second", -1, 8'h00);
  endtask

  task automatic test_parity();
    send(1, 8'h0A);
    check_frame(1, 8'h0A, "par_even", -1, 8'h00);
    checks++;
    if (cap[9 * CD + 1] !== 1'b0) begin
      failures++;
      $display("FAIL par_even bit: got %b want 0", cap[9 * CD + 1]);
    end
    send(2, 8'h0A);
    check_frame(2, 8'h0A, "par_odd", -1, 8'h00);
    checks++;
    if (cap[9 * CD + 1] !== 1'b1) begin
      failures++;
      $display("FAIL par_odd bit: got %b want 1", cap[9 * CD + 1]);
    end
    send(3, 8'h0A);
    check_frame(3, 8'h0A, "par_stop2", -1, 8'h00);
  endtask

  task automatic test_reset_mid();
    send(0, 8'h33);
    repeat (17) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid bit3: tx=%b busy=%b want tx=0 busy=1", tx_w[0], busy_w[0]);
    end
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid abort: tx=%b busy=%b want tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid idle: tx=%b busy=%b want tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    send(0, 8'hFF);
    check_frame(0, 8'hFF, "rstmid_FF", -1, 8'h00);
  endtask

  task automatic test_string();
    logic [7:0] line [4];
    line = '{8'h50, 8'h30, 8'h2C, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      send(0, line[i]);
      check_frame(0, line[i], "string", -1, 8'h00);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_frame_shape();
    test_busy_ignore();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    test_string();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
